// File: rtl/apu_pkg.sv
// Shared constants and types for the APU pulse-channel register block.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package apu_pkg;

    // Default frame-sequencer step length in apu_clk cycles.
    localparam int STEP_CYCLES_DEF = 7457;

    // Register map: two pulse channels of four bytes each, then frame control.
    localparam logic [3:0] ADDR_P0_R0 = 4'd0;
    localparam logic [3:0] ADDR_P0_R1 = 4'd1;
    localparam logic [3:0] ADDR_P0_R2 = 4'd2;
    localparam logic [3:0] ADDR_P0_R3 = 4'd3;
    localparam logic [3:0] ADDR_P1_R0 = 4'd4;
    localparam logic [3:0] ADDR_P1_R1 = 4'd5;
    localparam logic [3:0] ADDR_P1_R2 = 4'd6;
    localparam logic [3:0] ADDR_P1_R3 = 4'd7;
    localparam logic [3:0] ADDR_FRAME = 4'd8;

    typedef enum logic {
        MODE_4STEP = 1'b0,
        MODE_5STEP = 1'b1
    } frame_mode_e;

    // Index of the final step before the sequencer returns to step 0.
    function automatic logic [2:0] last_step(input frame_mode_e mode);
        return (mode == MODE_5STEP) ? 3'd4 : 3'd3;
    endfunction

endpackage

// File: rtl/apu_frame_counter.sv
// Frame sequencer: step divider, quarter/half-frame strobes and sticky frame IRQ.
// Latency: strobes and IRQ are registered, visible the cycle after the wrap or control write.
// Backpressure: none; control writes are always taken and restart the sequence.
module apu_frame_counter
    import apu_pkg::*;
#(
    parameter int STEP_CYCLES = STEP_CYCLES_DEF
) (
    input  logic apu_clk,
    input  logic rst_n,
    input  logic ctrl_wr_i,
    input  logic ctrl_mode_i,
    input  logic ctrl_inhibit_i,
    input  logic irq_ack_i,
    output logic qtr_clk_o,
    output logic hlf_clk_o,
    output logic frame_irq_o
);

    localparam int DW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

    logic [DW-1:0] div_q, div_d;
    logic [2:0]    step_q, step_d;
    frame_mode_e   mode_q, mode_d;
    logic          inh_q, inh_d;
    logic          qtr_q, qtr_d;
    logic          hlf_q, hlf_d;
    logic          irq_q, irq_d;

    // State register with synchronous active-low reset.
    always_ff @(posedge apu_clk) begin
        if (!rst_n) begin
            div_q  <= '0;
            step_q <= '0;
            mode_q <= MODE_4STEP;
            inh_q  <= 1'b0;
            qtr_q  <= 1'b0;
            hlf_q  <= 1'b0;
            irq_q  <= 1'b0;
        end else begin
            div_q  <= div_d;
            step_q <= step_d;
            mode_q <= mode_d;
            inh_q  <= inh_d;
            qtr_q  <= qtr_d;
            hlf_q  <= hlf_d;
            irq_q  <= irq_d;
        end
    end

    // Next-state: a control write overrides the wrap; the IRQ set is applied after
    // the acknowledge so a coincident set wins.
    always_comb begin
        div_d  = div_q;
        step_d = step_q;
        mode_d = mode_q;
        inh_d  = inh_q;
        qtr_d  = 1'b0;
        hlf_d  = 1'b0;
        irq_d  = irq_q;

        if (irq_ack_i) begin
            irq_d = 1'b0;
        end

        if (ctrl_wr_i) begin
            mode_d = frame_mode_e'(ctrl_mode_i);
            inh_d  = ctrl_inhibit_i;
            div_d  = '0;
            step_d = '0;
            if (ctrl_mode_i) begin
                qtr_d = 1'b1;
                hlf_d = 1'b1;
            end
            if (ctrl_inhibit_i) begin
                irq_d = 1'b0;
            end
        end else if (div_q == DW'(STEP_CYCLES - 1)) begin
            div_d  = '0;
            step_d = (step_q == last_step(mode_q)) ? 3'd0 : step_q + 3'd1;
            if (mode_q == MODE_4STEP) begin
                qtr_d = 1'b1;
                hlf_d = step_q[0];
                if ((step_q == 3'd3) && !inh_q) begin
                    irq_d = 1'b1;
                end
            end else begin
                qtr_d = (step_q != 3'd3);
                hlf_d = (step_q == 3'd1) || (step_q == 3'd4);
            end
        end else begin
            div_d = div_q + DW'(1);
        end
    end

    assign qtr_clk_o   = qtr_q;
    assign hlf_clk_o   = hlf_q;
    assign frame_irq_o = irq_q;

endmodule

// File: rtl/apu_pulse_ctrl.sv
// Pulse-channel register file with write handshake, plus frame sequencer instance.
// Latency: register bytes and change toggles update the cycle after an accepted write.
// Backpressure: wr_ready drops for HOLD_CYCLES cycles after any reg_3 write; else always ready.
module apu_pulse_ctrl
    import apu_pkg::*;
#(
    parameter int STEP_CYCLES = STEP_CYCLES_DEF,
    parameter int HOLD_CYCLES = 4
) (
    input  logic        apu_clk,
    input  logic        rst_n,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [3:0]  wr_addr,
    input  logic [7:0]  wr_data,
    output logic [31:0] p0_regs,
    output logic [31:0] p1_regs,
    output logic        p0_change,
    output logic        p1_change,
    output logic        qtr_clk,
    output logic        hlf_clk,
    input  logic        irq_ack,
    output logic        frame_irq
);

    localparam int HW = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;

    logic [31:0]   p0_q, p0_d;
    logic [31:0]   p1_q, p1_d;
    logic          p0_chg_q, p0_chg_d;
    logic          p1_chg_q, p1_chg_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          wr_acc;
    logic          frame_wr;

    assign wr_ready = (hold_q == '0);
    assign wr_acc   = wr_valid && wr_ready;

    // Register file state with synchronous active-low reset.
    always_ff @(posedge apu_clk) begin
        if (!rst_n) begin
            p0_q     <= '0;
            p1_q     <= '0;
            p0_chg_q <= 1'b0;
            p1_chg_q <= 1'b0;
            hold_q   <= '0;
        end else begin
            p0_q     <= p0_d;
            p1_q     <= p1_d;
            p0_chg_q <= p0_chg_d;
            p1_chg_q <= p1_chg_d;
            hold_q   <= hold_d;
        end
    end

    // Address decode: byte writes, reg_3 toggles the channel flag and starts the hold.
    always_comb begin
        p0_d     = p0_q;
        p1_d     = p1_q;
        p0_chg_d = p0_chg_q;
        p1_chg_d = p1_chg_q;
        hold_d   = (hold_q != '0) ? hold_q - HW'(1) : hold_q;
        frame_wr = 1'b0;

        if (wr_acc) begin
            case (wr_addr)
                ADDR_P0_R0: p0_d[7:0]   = wr_data;
                ADDR_P0_R1: p0_d[15:8]  = wr_data;
                ADDR_P0_R2: p0_d[23:16] = wr_data;
                ADDR_P0_R3: begin
                    p0_d[31:24] = wr_data;
                    p0_chg_d    = ~p0_chg_q;
                    hold_d      = HW'(HOLD_CYCLES);
                end
                ADDR_P1_R0: p1_d[7:0]   = wr_data;
                ADDR_P1_R1: p1_d[15:8]  = wr_data;
                ADDR_P1_R2: p1_d[23:16] = wr_data;
                ADDR_P1_R3: begin
                    p1_d[31:24] = wr_data;
                    p1_chg_d    = ~p1_chg_q;
                    hold_d      = HW'(HOLD_CYCLES);
                end
                ADDR_FRAME: frame_wr = 1'b1;
                default:    ;
            endcase
        end
    end

    assign p0_regs   = p0_q;
    assign p1_regs   = p1_q;
    assign p0_change = p0_chg_q;
    assign p1_change = p1_chg_q;

    apu_frame_counter #(
        .STEP_CYCLES(STEP_CYCLES)
    ) u_frame (
        .apu_clk       (apu_clk),
        .rst_n         (rst_n),
        .ctrl_wr_i     (frame_wr),
        .ctrl_mode_i   (wr_data[7]),
        .ctrl_inhibit_i(wr_data[6]),
        .irq_ack_i     (irq_ack),
        .qtr_clk_o     (qtr_clk),
        .hlf_clk_o     (hlf_clk),
        .frame_irq_o   (frame_irq)
    );

endmodule

// File: tb/tb_apu_pulse_ctrl.sv
// Directed bench for apu_pulse_ctrl with STEP_CYCLES=8, HOLD_CYCLES=4.
// Inputs change 1 ns after each rising edge; outputs are sampled at the same point.
// Each scenario task carries its own hand-computed expectations.
module tb_apu_pulse_ctrl;

    logic        apu_clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [3:0]  wr_addr = 4'd0;
    logic [7:0]  wr_data = 8'd0;
    logic [31:0] p0_regs, p1_regs;
    logic        p0_change, p1_change;
    logic        qtr_clk, hlf_clk;
    logic        irq_ack = 1'b0;
    logic        frame_irq;

    int vec = 0;
    int errs = 0;

    // 5-step strobe table indexed by step: qtr on 0,1,2,4; hlf on 1,4.
    localparam logic [4:0] Q5 = 5'b10111;
    localparam logic [4:0] H5 = 5'b10010;

    always #5 apu_clk = ~apu_clk;

    apu_pulse_ctrl #(
        .STEP_CYCLES(8),
        .HOLD_CYCLES(4)
    ) dut (
        .apu_clk  (apu_clk),
        .rst_n    (rst_n),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .p0_regs  (p0_regs),
        .p1_regs  (p1_regs),
        .p0_change(p0_change),
        .p1_change(p1_change),
        .qtr_clk  (qtr_clk),
        .hlf_clk  (hlf_clk),
        .irq_ack  (irq_ack),
        .frame_irq(frame_irq)
    );

    task automatic tick();
        @(posedge apu_clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        vec++; if (wr_ready !== 1'b1) begin errs++; $display("FAIL reset wr_ready got=%b exp=1", wr_ready); end
        vec++; if (p0_regs !== 32'h0) begin errs++; $display("FAIL reset p0_regs got=%h exp=0", p0_regs); end
        vec++; if (p1_regs !== 32'h0) begin errs++; $display("FAIL reset p1_regs got=%h exp=0", p1_regs); end
        vec++; if ({p0_change, p1_change} !== 2'b00) begin errs++; $display("FAIL reset change got=%b%b exp=00", p0_change, p1_change); end
        vec++; if ({qtr_clk, hlf_clk} !== 2'b00) begin errs++; $display("FAIL reset strobes got=%b%b exp=00", qtr_clk, hlf_clk); end
        vec++; if (frame_irq !== 1'b0) begin errs++; $display("FAIL reset frame_irq got=%b exp=0", frame_irq); end
    endtask

    // 4-step from reset: qtr at 8,16,24,32; hlf at 16,32; irq from 32.
    task automatic test_four_step();
        logic eq, eh, ei;
        rst_n = 1'b1;
        for (int c = 1; c <= 32; c++) begin
            tick();
            eq = (c % 8 == 0);
            eh = (c % 16 == 0);
            ei = (c >= 32);
            vec++; if (qtr_clk !== eq) begin errs++; $display("FAIL four_step qtr c=%0d got=%b exp=%b", c, qtr_clk, eq); end
            vec++; if (hlf_clk !== eh) begin errs++; $display("FAIL four_step hlf c=%0d got=%b exp=%b", c, hlf_clk, eh); end
            vec++; if (frame_irq !== ei) begin errs++; $display("FAIL four_step irq c=%0d got=%b exp=%b", c, frame_irq, ei); end
        end
    endtask

    // Ack clears; ack coincident with the step-3 set loses; a later ack clears.
    task automatic test_irq_ack();
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        vec++; if (frame_irq !== 1'b0) begin errs++; $display("FAIL irq_ack clear got=%b exp=0", frame_irq); end
        for (int c = 34; c <= 63; c++) tick();
        vec++; if (frame_irq !== 1'b0) begin errs++; $display("FAIL irq_ack idle got=%b exp=0", frame_irq); end
        irq_ack = 1'b1;
        tick();
        vec++; if (frame_irq !== 1'b1) begin errs++; $display("FAIL irq_ack set_wins got=%b exp=1", frame_irq); end
        vec++; if ({qtr_clk, hlf_clk} !== 2'b11) begin errs++; $display("FAIL irq_ack step3 strobes got=%b%b exp=11", qtr_clk, hlf_clk); end
        tick();
        irq_ack = 1'b0;
        vec++; if (frame_irq !== 1'b0) begin errs++; $display("FAIL irq_ack later got=%b exp=0", frame_irq); end
    endtask

    task automatic test_reg_write();
        wr(4'd3, 8'h3F);
        vec++; if (p0_regs !== 32'h3F00_0000) begin errs++; $display("FAIL reg3 p0_regs got=%h exp=3f000000", p0_regs); end
        vec++; if (p0_change !== 1'b1) begin errs++; $display("FAIL reg3 p0_change got=%b exp=1", p0_change); end
        vec++; if (p1_change !== 1'b0) begin errs++; $display("FAIL reg3 p1_change got=%b exp=0", p1_change); end
        vec++; if (wr_ready !== 1'b0) begin errs++; $display("FAIL reg3 hold c=1 got=%b exp=0", wr_ready); end
        // A write presented during the hold must not be taken.
        wr_valid = 1'b1;
        wr_addr  = 4'd0;
        wr_data  = 8'h99;
        for (int c = 2; c <= 4; c++) begin
            tick();
            vec++; if (wr_ready !== 1'b0) begin errs++; $display("FAIL reg3 hold c=%0d got=%b exp=0", c, wr_ready); end
        end
        wr_valid = 1'b0;
        tick();
        vec++; if (wr_ready !== 1'b1) begin errs++; $display("FAIL reg3 release got=%b exp=1", wr_ready); end
        vec++; if (p0_regs !== 32'h3F00_0000) begin errs++; $display("FAIL reg3 blocked write got=%h exp=3f000000", p0_regs); end
        vec++; if (p0_change !== 1'b1) begin errs++; $display("FAIL reg3 single toggle got=%b exp=1", p0_change); end
    endtask

    task automatic test_back_to_back();
        wr(4'd0, 8'hAA);
        vec++; if (wr_ready !== 1'b1) begin errs++; $display("FAIL b2b ready0 got=%b exp=1", wr_ready); end
        wr(4'd1, 8'hBB);
        wr(4'd2, 8'hCC);
        vec++; if (p0_regs !== 32'h3FCC_BBAA) begin errs++; $display("FAIL b2b p0_regs got=%h exp=3fccbbaa", p0_regs); end
        vec++; if ({p0_change, wr_ready} !== 2'b11) begin errs++; $display("FAIL b2b chg/ready got=%b%b exp=11", p0_change, wr_ready); end
        wr(4'd5, 8'hA5);
        vec++; if (p1_regs !== 32'h0000_A500) begin errs++; $display("FAIL ch1 r1 got=%h exp=0000a500", p1_regs); end
        vec++; if (p1_change !== 1'b0) begin errs++; $display("FAIL ch1 r1 toggle got=%b exp=0", p1_change); end
        wr(4'd7, 8'h12);
        vec++; if (p1_regs !== 32'h1200_A500) begin errs++; $display("FAIL ch1 r3 got=%h exp=1200a500", p1_regs); end
        vec++; if ({p0_change, p1_change} !== 2'b11) begin errs++; $display("FAIL ch1 r3 toggles got=%b%b exp=11", p0_change, p1_change); end
        vec++; if (wr_ready !== 1'b0) begin errs++; $display("FAIL ch1 r3 hold got=%b exp=0", wr_ready); end
        for (int c = 0; c < 4; c++) tick();
        vec++; if (wr_ready !== 1'b1) begin errs++; $display("FAIL ch1 r3 release got=%b exp=1", wr_ready); end
        wr(4'd12, 8'hFF);
        vec++; if ({p0_regs, p1_regs} !== 64'h3FCC_BBAA_1200_A500) begin errs++; $display("FAIL unused addr regs got=%h_%h exp=3fccbbaa_1200a500", p0_regs, p1_regs); end
        vec++; if ({p0_change, p1_change, wr_ready} !== 3'b111) begin errs++; $display("FAIL unused addr flags got=%b%b%b exp=111", p0_change, p1_change, wr_ready); end
    endtask

    // 5-step write with immediate strobe pair, pattern check, then a 4-step
    // write landing on a wrap cycle.
    task automatic test_five_step_and_wrap();
        logic eq, eh;
        int s;
        irq_ack = 1'b1;
        wr(4'd8, 8'h80);
        irq_ack = 1'b0;
        vec++; if ({qtr_clk, hlf_clk} !== 2'b11) begin errs++; $display("FAIL five_step immediate got=%b%b exp=11", qtr_clk, hlf_clk); end
        vec++; if (frame_irq !== 1'b0) begin errs++; $display("FAIL five_step irq start got=%b exp=0", frame_irq); end
        for (int k = 1; k <= 55; k++) begin
            tick();
            s  = (k / 8 + 4) % 5;
            eq = (k % 8 == 0) ? Q5[s] : 1'b0;
            eh = (k % 8 == 0) ? H5[s] : 1'b0;
            vec++; if ({qtr_clk, hlf_clk} !== {eq, eh}) begin errs++; $display("FAIL five_step k=%0d got=%b%b exp=%b%b", k, qtr_clk, hlf_clk, eq, eh); end
            vec++; if (frame_irq !== 1'b0) begin errs++; $display("FAIL five_step irq k=%0d got=%b exp=0", k, frame_irq); end
        end
        wr(4'd8, 8'h00);
        vec++; if ({qtr_clk, hlf_clk} !== 2'b00) begin errs++; $display("FAIL wrap_write dropped got=%b%b exp=00", qtr_clk, hlf_clk); end
        for (int j = 1; j <= 8; j++) begin
            tick();
            eq = (j == 8);
            vec++; if ({qtr_clk, hlf_clk} !== {eq, 1'b0}) begin errs++; $display("FAIL wrap_write j=%0d got=%b%b exp=%b0", j, qtr_clk, hlf_clk, eq); end
        end
    endtask

    // Continues the 4-step run: irq sets at step 3, inhibit write clears and blocks it.
    task automatic test_inhibit();
        for (int j = 9; j <= 31; j++) tick();
        vec++; if (frame_irq !== 1'b0) begin errs++; $display("FAIL inhibit pre got=%b exp=0", frame_irq); end
        tick();
        vec++; if (frame_irq !== 1'b1) begin errs++; $display("FAIL inhibit set got=%b exp=1", frame_irq); end
        wr(4'd8, 8'h40);
        vec++; if (frame_irq !== 1'b0) begin errs++; $display("FAIL inhibit clear got=%b exp=0", frame_irq); end
        for (int j = 1; j <= 32; j++) tick();
        vec++; if ({qtr_clk, hlf_clk, frame_irq} !== 3'b110) begin errs++; $display("FAIL inhibit step3 got=%b%b%b exp=110", qtr_clk, hlf_clk, frame_irq); end
    endtask

    task automatic test_reset_in_hold();
        wr(4'd3, 8'h55);
        tick();
        vec++; if (wr_ready !== 1'b0) begin errs++; $display("FAIL rst_hold pre got=%b exp=0", wr_ready); end
        rst_n = 1'b0;
        tick();
        vec++; if (wr_ready !== 1'b1) begin errs++; $display("FAIL rst_hold ready got=%b exp=1", wr_ready); end
        vec++; if ({p0_regs, p1_regs} !== 64'h0) begin errs++; $display("FAIL rst_hold regs got=%h_%h exp=0", p0_regs, p1_regs); end
        vec++; if ({p0_change, p1_change, qtr_clk, hlf_clk, frame_irq} !== 5'b0) begin errs++; $display("FAIL rst_hold flags got=%b%b%b%b%b exp=00000", p0_change, p1_change, qtr_clk, hlf_clk, frame_irq); end
        rst_n = 1'b1;
        tick();
        vec++; if (wr_ready !== 1'b1) begin errs++; $display("FAIL rst_hold after got=%b exp=1", wr_ready); end
    endtask

    initial begin
        test_reset();
        test_four_step();
        test_irq_ack();
        test_reg_write();
        test_back_to_back();
        test_five_step_and_wrap();
        test_inhibit();
        test_reset_in_hold();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule

// File: doc/apu_pulse_ctrl.md
APU_PULSE_CTRL -- requirements
Module: apu_pulse_ctrl

Interface
REQ-001 SHALL have parameter STEP_CYCLES, default 7457: apu_clk cycles per frame-sequencer step.
REQ-002 SHALL have parameter HOLD_CYCLES, default 4: wr_ready low time after a reg_3 write.
REQ-003 SHALL have port apu_clk  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port wr_valid  input  1  register write request.
REQ-006 SHALL have port wr_ready  output  1  write accepted when wr_valid and wr_ready are both high.
REQ-007 SHALL have port wr_addr  input  4  0-3 = channel 0 reg_0..reg_3; 4-7 = channel 1 reg_0..reg_3; 8 = frame control; 9-15 unused.
REQ-008 SHALL have port wr_data  input  8  write data.
REQ-009 SHALL have port p0_regs  output  32  channel 0 {reg_3,reg_2,reg_1,reg_0}.
REQ-010 SHALL have port p1_regs  output  32  channel 1, same packing.
REQ-011 SHALL have port p0_change, p1_change  output  1 each  per-channel reload toggle.
REQ-012 SHALL have port qtr_clk, hlf_clk  output  1 each  one-cycle quarter-frame and half-frame strobes.
REQ-013 SHALL have port irq_ack  input  1  clears frame_irq.
REQ-014 SHALL have port frame_irq  output  1  sticky frame interrupt.

Function
REQ-015 SHALL store wr_data into the addressed register byte on an accepted write; the output reflects it the following cycle.
REQ-016 SHALL invert pX_change in the same cycle the channel's reg_3 byte updates; writes to reg_0..reg_2 do not toggle.
REQ-017 SHALL drive wr_ready low for exactly HOLD_CYCLES cycles after an accepted reg_3 write (either channel); all other writes leave wr_ready high.
REQ-018 SHALL accept writes to addresses 9-15 with no state change.
REQ-019 SHALL hold frame control as mode (wr_data[7]: 0 = 4-step, 1 = 5-step) and irq_inhibit (wr_data[6]).
REQ-020 Frame sequencer SHALL use divider 0..STEP_CYCLES-1; at each wrap, step advances 0..3 (4-step) or 0..4 (5-step), then returns to 0.
REQ-021 4-step mode: qtr_clk on every step; hlf_clk on steps 1 and 3; step 3 sets frame_irq when irq_inhibit = 0.
REQ-022 5-step mode: qtr_clk on steps 0,1,2,4; hlf_clk on steps 1 and 4; step 3 silent; never sets frame_irq.
REQ-023 Strobes SHALL be registered, high exactly one apu_clk cycle, and coincident when both are due.
REQ-024 Accepted frame-control write SHALL clear divider and step to 0; any strobe due that cycle is dropped.
REQ-025 Frame-control write with mode = 1 SHALL emit qtr_clk and hlf_clk together on the next cycle.
REQ-026 Frame-control write with irq_inhibit = 1 SHALL clear frame_irq.
REQ-027 irq_ack SHALL clear frame_irq next cycle; when a set event coincides, the set wins.

Reset
REQ-028 SHALL, with rst_n low at a clock edge, clear registers, change toggles, strobes, frame_irq, divider, step, mode and inhibit to 0.
REQ-029 SHALL set wr_ready to 1 out of reset and abort any hold countdown.

Structure
REQ-030 Package apu_pkg SHALL hold address constants (ADDR_P0_R0..ADDR_FRAME), the frame-mode enum and the default STEP_CYCLES.
REQ-031 Frame divider, step counter and strobe/IRQ generation SHALL live in sub-module apu_frame_counter; the register file and handshake stay at top level.

Verification
REQ-032 Reset, then STEP_CYCLES=8 and mode 4-step -> qtr_clk at cycles 8,16,24,32; hlf_clk at 16,32; frame_irq set at 32.
REQ-033 Write 0x80 to addr 8 -> qtr_clk and hlf_clk together next cycle, then the 5-step pattern with no frame_irq.
REQ-034 Write 0x3F to addr 3 -> p0_regs[31:24]=0x3F, p0_change toggles once, wr_ready low for 4 cycles; p1_change stays constant.
REQ-035 Frame-control write in the divider-wrap cycle -> no strobe that cycle; next strobe STEP_CYCLES later.
REQ-036 irq_ack asserted during the step-3 set cycle -> frame_irq stays 1; a later irq_ack clears it.
REQ-037 rst_n low during the hold window -> wr_ready 1 and all outputs 0 the cycle after.
